// File: rtl/bk_pkg.sv
// Shared types and sizing helpers for the nibble-serial Brent-Kung adder.
package bk_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bk_state_e;

    // Index width for a nibble counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/brent_kung_cin.sv
// 4-bit Brent-Kung prefix adder with carry-in; s[4] is the carry-out.
// Latency: combinational. Backpressure: none.
module brent_kung_cin (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [7:0] s
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic       g10, p10, g32, p32, g20, p20, g30, p30;
    logic       unused_ab;

    assign unused_ab = ^{a[5:4], b[5:4]};

    always_comb begin
        g   = a[3:0] & b[3:0];
        p   = a[3:0] ^ b[3:0];
        // Up-sweep builds pair and quad prefixes, down-sweep fills bit 2.
        g10 = g[1] | (p[1] & g[0]);
        p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g30 = g32 | (p32 & g10);
        p30 = p32 & p10;
        g20 = g[2] | (p[2] & g10);
        p20 = p[2] & p10;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g10 | (p10 & cin);
        c[3] = g20 | (p20 & cin);
        c[4] = g30 | (p30 & cin);
        s    = {3'b000, c[4], p ^ c[3:0]};
    end

endmodule

// File: rtl/bk_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit Brent-Kung slice per cycle, carry held in a flop.
// Latency: out_valid rises NIBBLES cycles after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module bk_serial_adder
    import bk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("bk_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    bk_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    logic [IDX_W+1:0] nib_base;
    logic [3:0]       a_nib, b_nib;
    logic [7:0]       slice_s;
    logic             unused_slice;

    assign nib_base     = {idx_q, 2'b00};
    assign a_nib        = a_q[nib_base +: NIBBLE_W];
    assign b_nib        = b_q[nib_base +: NIBBLE_W];
    assign unused_slice = ^slice_s[7:5];

    brent_kung_cin u_slice (
        .a   ({2'b00, a_nib}),
        .b   ({2'b00, b_nib}),
        .cin (carry_q),
        .s   (slice_s)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[nib_base +: NIBBLE_W] = slice_s[3:0];
                carry_d = slice_s[4];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // Carry into the MSB is recovered from the MSB sum bit and its operands.
                    cout_d  = slice_s[4];
                    ovf_d   = slice_s[4] ^ (slice_s[3] ^ a_nib[3] ^ b_nib[3]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
